// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states, divider constants.
// MULDIV_MAC_EN (defined in the build) enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package muldiv_unit_pkg;

    localparam int FUNCT_BUS = 6;
    typedef logic [FUNCT_BUS-1:0] funct_t;

    // SPECIAL-class funct codes
    localparam funct_t FUNCT_MFHI  = 6'h10;
    localparam funct_t FUNCT_MTHI  = 6'h11;
    localparam funct_t FUNCT_MFLO  = 6'h12;
    localparam funct_t FUNCT_MTLO  = 6'h13;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;

    // SPECIAL2-class funct codes
    localparam funct_t FUNCT2_MADD  = 6'h00;
    localparam funct_t FUNCT2_MADDU = 6'h01;
    localparam funct_t FUNCT2_MUL   = 6'h02;
    localparam funct_t FUNCT2_MSUB  = 6'h04;
    localparam funct_t FUNCT2_MSUBU = 6'h05;

    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = DIV_ITERS + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit_div.sv
// Radix-2 restoring divider on operand magnitudes; signs restored on the outputs.
// Loads on start, then one quotient bit per cycle; done pulses after the last iteration.
module div_iter
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [31:0] q_q, r_q, d_q;
    logic        neg_q_q, neg_r_q;
    logic        busy_q, done_q;
    logic [4:0]  cnt_q;

    logic [31:0] a_mag, b_mag;
    logic [32:0] r_sh, diff;

    assign a_mag = (is_signed && a[31]) ? -a : a;
    assign b_mag = (is_signed && b[31]) ? -b : b;
    assign r_sh  = {r_q, q_q[31]};
    assign diff  = r_sh - {1'b0, d_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start) begin
                q_q     <= a_mag;
                r_q     <= '0;
                d_q     <= b_mag;
                neg_q_q <= is_signed & (a[31] ^ b[31]);
                neg_r_q <= is_signed & a[31];
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                // A clear borrow bit means the divisor fit: keep the difference.
                q_q   <= {q_q[30:0], ~diff[32]};
                r_q   <= diff[32] ? r_sh[31:0] : diff[31:0];
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = neg_q_q ? -q_q : q_q;
    assign rem  = neg_r_q ? -r_q : r_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit; one op in flight, HI/LO committed on the output handshake.
// MULDIV_MAC_EN enables MADD/MADDU/MSUB/MSUBU; without it those codes report out_ill.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FUNCT_BUS-1:0] in_funct,
    input  logic [5:0]           in_tag,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_tag,
    output logic [31:0]          out_data,
    output logic                 out_wen,
    output logic                 out_ill
);

    state_t      state_q, state_d;
    funct_t      funct_q, funct_d;
    logic [5:0]  tag_q, tag_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic        hilo_wr_q, hilo_wr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_wen_q, out_wen_d, out_ill_q, out_ill_d;

    logic        accept, is_mul, is_div, mul_signed;
    logic [63:0] ext_a, ext_b, prod, acc;
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        is_mul = (in_funct == FUNCT_MULT) || (in_funct == FUNCT_MULTU) || (in_funct == FUNCT2_MUL);
`ifdef MULDIV_MAC_EN
        is_mul = is_mul || (in_funct inside {FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU});
`endif
        is_div = (in_funct == FUNCT_DIV) || (in_funct == FUNCT_DIVU);
    end

    // Sign/zero extension to 64 bits lets one multiplier serve both signednesses.
    assign mul_signed = funct_q inside {FUNCT_MULT, FUNCT2_MUL, FUNCT2_MADD, FUNCT2_MSUB};
    assign ext_a = {{32{mul_signed & a_q[31]}}, a_q};
    assign ext_b = {{32{mul_signed & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    always_comb begin
        acc = prod;
`ifdef MULDIV_MAC_EN
        if (funct_q inside {FUNCT2_MADD, FUNCT2_MADDU}) begin
            acc = {hi_q, lo_q} + prod;
        end else if (funct_q inside {FUNCT2_MSUB, FUNCT2_MSUBU}) begin
            acc = {hi_q, lo_q} - prod;
        end
`endif
    end

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept & is_div),
        .abort     (flush),
        .is_signed (in_funct == FUNCT_DIV),
        .a         (in_a),
        .b         (in_b),
        .busy      (div_busy),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_comb begin
        state_d    = state_q;
        funct_d    = funct_q;
        tag_d      = tag_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        hilo_wr_d  = hilo_wr_q;
        out_data_d = out_data_q;
        out_wen_d  = out_wen_q;
        out_ill_d  = out_ill_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct_d    = in_funct;
                        tag_d      = in_tag;
                        a_d        = in_a;
                        b_d        = in_b;
                        res_hi_d   = hi_q;
                        res_lo_d   = lo_q;
                        hilo_wr_d  = 1'b0;
                        out_data_d = '0;
                        out_wen_d  = 1'b0;
                        out_ill_d  = 1'b0;
                        if (is_mul) begin
                            state_d = MUL;
                        end else if (is_div) begin
                            state_d = DIV;
                        end else begin
                            state_d = DONE;
                            case (in_funct)
                                FUNCT_MFHI: begin out_data_d = hi_q; out_wen_d = 1'b1; end
                                FUNCT_MFLO: begin out_data_d = lo_q; out_wen_d = 1'b1; end
                                FUNCT_MTHI: begin res_hi_d = in_a; hilo_wr_d = 1'b1; end
                                FUNCT_MTLO: begin res_lo_d = in_a; hilo_wr_d = 1'b1; end
                                default:    out_ill_d = 1'b1;
                            endcase
                        end
                    end
                end
                MUL: begin
                    state_d = DONE;
                    if (funct_q == FUNCT2_MUL) begin
                        out_data_d = prod[31:0];
                        out_wen_d  = 1'b1;
                    end else begin
                        hilo_wr_d = 1'b1;
                        {res_hi_d, res_lo_d} = acc;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_d   = DONE;
                        hilo_wr_d = 1'b1;
                        if (b_q == 32'd0) begin
                            res_lo_d = 32'hFFFF_FFFF;
                            res_hi_d = a_q;
                        end else begin
                            res_lo_d = div_quot;
                            res_hi_d = div_rem;
                        end
                    end else if (!div_busy) begin
                        // Divider lost its operation; recover instead of hanging.
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        if (hilo_wr_q) begin
                            hi_d = res_hi_q;
                            lo_d = res_lo_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            funct_q    <= '0;
            tag_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            hilo_wr_q  <= 1'b0;
            out_data_q <= '0;
            out_wen_q  <= 1'b0;
            out_ill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct_q    <= funct_d;
            tag_q      <= tag_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            hilo_wr_q  <= hilo_wr_d;
            out_data_q <= out_data_d;
            out_wen_q  <= out_wen_d;
            out_ill_q  <= out_ill_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_tag   = tag_q;
    assign out_data  = out_data_q;
    assign out_wen   = out_wen_q;
    assign out_ill   = out_ill_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  issue request; in_ready  out  1  unit can accept.
REQ-004 SHALL have ports: in_funct  in  6 (FUNCT_BUS)  op code from ID funct generation; in_tag  in  6  ROB tag.
REQ-005 SHALL have ports: in_a  in  32  rs operand; in_b  in  32  rt operand.
REQ-006 SHALL have ports: out_valid  out  1  result ready; out_ready  in  1  writeback accepts.
REQ-007 SHALL have ports: out_tag  out  6; out_data  out  32; out_wen  out  1  GPR write; out_ill  out  1  unsupported funct.
REQ-008 SHALL have ports: flush  in  1  pipeline flush, synchronous.

Function
REQ-009 SHALL decode ops FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO, FUNCT2_MUL, FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU.
REQ-010 SHALL hold internal 32-bit HI and LO registers.
REQ-011 SHALL use FSM states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE; accept = in_valid & in_ready.
REQ-012 SHALL go from IDLE, on accept of MFHI/MFLO/MTHI/MTLO/unsupported, to DONE: out_valid the next cycle.
REQ-013 SHALL go from IDLE, on accept of multiply-class ops, to MUL (1 cycle), then DONE: out_valid 2 cycles after accept.
REQ-014 SHALL go from IDLE, on accept of DIV/DIVU, to DIV for 33 cycles (1 setup, 32 radix-2 iterations), then DONE: out_valid 34 cycles after accept.
REQ-015 SHALL hold out_* stable in DONE until out_ready; on out_valid&out_ready, return to IDLE; in_ready rises the following cycle.
REQ-016 SHALL commit HI/LO only on the out handshake; MULT/MULTU/DIV/DIVU/MADD*/MSUB*/MTHI/MTLO update, all others leave HI/LO unchanged.
REQ-017 SHALL compute MULT/MULTU as {HI,LO} = 64-bit signed/unsigned product; MUL: out_data = low 32 bits, out_wen=1, HI/LO unchanged.
REQ-018 SHALL compute MADD(U)/MSUB(U) as {HI,LO} = {HI,LO} +/- product, modulo 2^64, using the pre-commit HI/LO.
REQ-019 SHALL compute DIV/DIVU as LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-020 SHALL on divide by zero set LO=0xFFFFFFFF, HI=in_a; latency unchanged.
REQ-021 SHALL on 0x80000000 / 0xFFFFFFFF (signed) set LO=0x80000000, HI=0.
REQ-022 SHALL drive out_data=HI/LO with out_wen=1 for MFHI/MFLO; out_wen=0 for all HI/LO-only ops.
REQ-023 SHALL treat any other in_funct as unsupported: out_ill=1, out_wen=0, no HI/LO change.
REQ-024 SHALL on flush, in any state, go to IDLE next cycle, drop the in-flight op without HI/LO write, and ignore a same-cycle in_valid.
REQ-025 SHALL give flush priority over the out handshake when both occur in the same cycle (no commit).

Reset
REQ-026 SHALL on rst asynchronously force state=IDLE, HI=LO=0, out_valid=0, out_wen=0, out_ill=0, out_data=0, out_tag=0; in_ready=1 after release.
REQ-027 SHALL abandon an op in progress at reset mid-operation, with no commit.

Configuration
REQ-028 SHALL use macro MULDIV_MAC_EN: defined = FUNCT2_MADD/MADDU/MSUB/MSUBU supported per REQ-018.
REQ-029 SHALL, with MULDIV_MAC_EN undefined, treat those four codes as unsupported per REQ-023 and omit the 64-bit accumulator adder.

Structure
REQ-030 SHALL take FUNCT_*/FUNCT2_* codes and FUNCT_BUS from the shared funct/bus headers; FSM state encodings and the DIV latency constant go in a new shared muldiv header.
REQ-031 SHALL implement the iterative divider as sub-module div_iter (start, signed, a, b -> busy, done, quot, rem).

Verification
REQ-032 SHALL test: MULT a=0xFFFFFFFF b=2 -> out_valid at +2, out_wen=0; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFE.
REQ-033 SHALL test: DIV a=-7 b=2 -> out_valid at +34; MFLO=0xFFFFFFFD, MFHI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-034 SHALL test: MTHI 0, MTLO 5, MADD 3*4 -> MFLO=17 (MAC_EN); without MAC_EN, out_ill=1 and MFLO=5.
REQ-035 SHALL test: DIV issued, flush at cycle 10 -> in_ready=1 next cycle, HI/LO unchanged, no out_valid.
REQ-036 SHALL test: MUL 6*7 with out_ready low 5 cycles -> out_data=42, tag stable, in_ready=0 until handshake.
REQ-037 SHALL test: rst asserted mid-DIV -> all outputs zero immediately, HI=LO=0.
